// File: rtl/data_bus_controller.sv
// rtl/data_bus_controller.sv - load/store request port in front of a word RAM and a status register window
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   req_valid/req_ready       request handshake (one outstanding request)
//   req_we, req_size,         store flag, access size (byte/half/word),
//   req_unsigned, req_addr,   load zero-extend flag, byte address,
//   req_wdata                 right-aligned store data
//   rsp_valid/rsp_ready       response handshake, held until taken
//   rsp_rdata, rsp_err        right-aligned extended load data, error code
//   busy                      controller not idle
module data_bus_controller #(
  parameter logic [31:0] RAM_START    = 32'h0000_1000,
  parameter int          RAM_WORDS    = 1024,
  parameter logic [31:0] REG_START    = 32'hFFFF_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) * 32'd4;
  localparam logic [1:0]  LAT_INIT  = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [1:0]  lat_cnt;
  logic        mis_flag;
  logic        unm_flag;
  logic [15:0] err_cnt;
  logic [31:0] bad_addr;
  logic [31:0] res_rdata;
  logic [1:0]  res_err;

  logic [31:0] mem [RAM_WORDS];

  logic             accept;
  logic             misaligned;
  logic             in_ram;
  logic             in_reg;
  logic [1:0]       dec_err;
  logic [31:0]      ram_off;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_word;
  logic [31:0]      lane_shift;
  logic [31:0]      lane_data;
  logic [31:0]      reg_rdata;
  logic [31:0]      ld_data;
  logic [31:0]      res_data;
  logic [3:0]       wmask;
  logic [31:0]      wdata_al;

  // The request is fully evaluated in the accept cycle: the result and all
  // side effects are captured on the accept edge, so the registered copies
  // below stand in for the latched request fields for the rest of the access.
  always_comb begin
    accept     = req_valid && (state == S_IDLE);
    misaligned = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    ram_off    = req_addr - RAM_START;
    in_ram     = ram_off < RAM_BYTES;
    in_reg     = req_addr[31:4] == REG_START[31:4];

    if (misaligned)                          dec_err = 2'b01;
    else if (!in_ram && !in_reg)             dec_err = 2'b10;
    else if (in_reg && req_size != 2'b10)    dec_err = 2'b01;
    else                                     dec_err = 2'b00;

    ram_idx    = ram_off[IDX_W+1:2];
    ram_word   = mem[ram_idx];
    lane_shift = ram_word >> {req_addr[1:0], 3'b000};

    case (req_size)
      2'b00:   lane_data = {{24{lane_shift[7] & ~req_unsigned}}, lane_shift[7:0]};
      2'b01:   lane_data = {{16{lane_shift[15] & ~req_unsigned}}, lane_shift[15:0]};
      default: lane_data = ram_word;
    endcase

    case (req_addr[3:2])
      2'b00:   reg_rdata = {err_cnt, 14'd0, unm_flag, mis_flag};
      2'b01:   reg_rdata = bad_addr;
      default: reg_rdata = 32'd0;
    endcase

    ld_data  = in_reg ? reg_rdata : lane_data;
    res_data = (dec_err != 2'b00 || req_we) ? 32'd0 : ld_data;

    case (req_size)
      2'b00: begin
        wdata_al = {4{req_wdata[7:0]}};
        wmask    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wdata_al = {2{req_wdata[15:0]}};
        wmask    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_al = req_wdata;
        wmask    = 4'b1111;
      end
    endcase
  end

  // RAM is never reset; stores land on the accept edge so any later load sees them.
  always_ff @(posedge clk) begin
    if (rst && accept && req_we && in_ram && dec_err == 2'b00) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[ram_idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 2'b00;
      lat_cnt   <= 2'd0;
      res_rdata <= 32'd0;
      res_err   <= 2'b00;
      mis_flag  <= 1'b0;
      unm_flag  <= 1'b0;
      err_cnt   <= 16'd0;
      bad_addr  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (dec_err != 2'b00) begin
              bad_addr <= req_addr;
              if (dec_err == 2'b01) mis_flag <= 1'b1;
              if (dec_err == 2'b10) unm_flag <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else if (req_we && in_reg && req_addr[3:2] == 2'b00) begin
              if (req_wdata[0]) mis_flag <= 1'b0;
              if (req_wdata[1]) unm_flag <= 1'b0;
              if (req_wdata[2]) err_cnt  <= 16'd0;
            end
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (READ_LATENCY == 1) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= res_data;
              rsp_err   <= dec_err;
            end else begin
              state     <= S_WAIT;
              lat_cnt   <= LAT_INIT;
              res_rdata <= res_data;
              res_err   <= dec_err;
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= res_rdata;
            rsp_err   <= res_err;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 2'b00;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
